img_rom_arbiter: RTL and testbench

//  Shares the single-port image ROM (blk_mem_gen_0, 12-bit pixels, 17-bit address) among NREQ pixel fetchers.

---
 rtl/img_rom_arbiter.sv | 166 ++++++++++++++++
 tb/tb_img_rom_arbiter.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/img_rom_arbiter.sv
// Shares one single-port image ROM among NREQ pixel fetchers. Requester 0 has
// fixed priority, capped by a starvation counter; the rest are served round-robin.
module img_rom_arbiter #(
  parameter int NREQ       = 4,
  parameter int AW         = 17,
  parameter int DW         = 12,
  parameter int RD_LAT     = 1,
  parameter int STARVE_MAX = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*AW-1:0] addr_in,
  output logic [NREQ-1:0]   gnt,
  output logic [NREQ-1:0]   rvalid,
  output logic [DW-1:0]     rdata,
  output logic [AW-1:0]     rom_addr,
  output logic              rom_en,
  input  logic [DW-1:0]     rom_dout
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;

  logic [PW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [CW-1:0]   starve_q, starve_d;
  logic [AW-1:0]   rom_addr_q, rom_addr_d;
  logic            rom_en_q;
  logic [NREQ-1:0] rvalid_q, rvalid_d;
  logic [DW-1:0]   rdata_q;

  logic [AW-1:0]   addr_arr [NREQ];
  logic [PW-1:0]   rr_win;
  logic            rr_found;
  logic            others;
  logic            override;
  logic [NREQ-1:0] gnt_raw;
  logic [PW-1:0]   win_idx;
  logic            accept;

  // Tag pipeline: stage 0 is loaded at the accept edge, stage RD_LAT lines up
  // with rom_dout being valid for that accept.
  logic            tag_vld_q [RD_LAT+1];
  logic [PW-1:0]   tag_id_q  [RD_LAT+1];

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_addr
      assign addr_arr[gi] = addr_in[gi*AW +: AW];
    end
  endgenerate

  // Round-robin search over 1..NREQ-1 starting at rr_ptr, wrapping once.
  always_comb begin
    rr_found = 1'b0;
    rr_win   = '0;
    for (int i = 1; i < NREQ; i++) begin
      if (!rr_found && req[i] && (PW'(i) >= rr_ptr_q)) begin
        rr_found = 1'b1;
        rr_win   = PW'(i);
      end
    end
    for (int i = 1; i < NREQ; i++) begin
      if (!rr_found && req[i] && (PW'(i) < rr_ptr_q)) begin
        rr_found = 1'b1;
        rr_win   = PW'(i);
      end
    end
  end

  assign others   = |req[NREQ-1:1];
  assign override = (STARVE_MAX != 0) && (starve_q == CW'(STARVE_MAX)) && others;

  always_comb begin
    gnt_raw = '0;
    win_idx = '0;
    if (req[0] && !override) begin
      gnt_raw[0] = 1'b1;
    end else if (rr_found) begin
      gnt_raw[rr_win] = 1'b1;
      win_idx         = rr_win;
    end
  end

  assign gnt    = rst_n ? gnt_raw : '0;
  assign accept = |gnt;

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (accept && !gnt[0]) begin
      rr_ptr_d = (win_idx == PW'(NREQ - 1)) ? PW'(1) : win_idx + PW'(1);
    end
  end

  // Counts req0 wins that happened while someone else was waiting.
  always_comb begin
    starve_d = starve_q;
    if (!others || (accept && !gnt[0])) begin
      starve_d = '0;
    end else if (gnt[0] && (starve_q != CW'(STARVE_MAX))) begin
      starve_d = starve_q + CW'(1);
    end
  end

  assign rom_addr_d = accept ? addr_arr[win_idx] : rom_addr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q   <= PW'(1);
      starve_q   <= '0;
      rom_addr_q <= '0;
      rom_en_q   <= 1'b0;
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      starve_q   <= starve_d;
      rom_addr_q <= rom_addr_d;
      rom_en_q   <= accept;
    end
  end

  generate
    for (gi = 0; gi <= RD_LAT; gi++) begin : g_tag
      if (gi == 0) begin : g_head
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) begin
            tag_vld_q[0] <= 1'b0;
            tag_id_q[0]  <= '0;
          end else begin
            tag_vld_q[0] <= accept;
            tag_id_q[0]  <= win_idx;
          end
        end
      end else begin : g_stage
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) begin
            tag_vld_q[gi] <= 1'b0;
            tag_id_q[gi]  <= '0;
          end else begin
            tag_vld_q[gi] <= tag_vld_q[gi-1];
            tag_id_q[gi]  <= tag_id_q[gi-1];
          end
        end
      end
    end
  endgenerate

  assign rvalid_d = tag_vld_q[RD_LAT] ? (NREQ'(1) << tag_id_q[RD_LAT]) : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rvalid_q <= '0;
      rdata_q  <= '0;
    end else begin
      rvalid_q <= rvalid_d;
      if (tag_vld_q[RD_LAT]) begin
        rdata_q <= rom_dout;
      end
    end
  end

  assign rom_addr = rom_addr_q;
  assign rom_en   = rom_en_q;
  assign rvalid   = rvalid_q;
  assign rdata    = rdata_q;

endmodule

// File: tb/tb_img_rom_arbiter.sv
// Randomized bench for img_rom_arbiter: a priority/round-robin reference model
// predicts every grant, and a scoreboard checks each tagged read return.
module tb_img_rom_arbiter;

  localparam int NREQ       = 4;
  localparam int AW         = 17;
  localparam int DW         = 12;
  localparam int RD_LAT     = 1;
  localparam int STARVE_MAX = 8;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NREQ-1:0]   req;
  logic [NREQ*AW-1:0] addr_in;
  logic [NREQ-1:0]   gnt;
  logic [NREQ-1:0]   rvalid;
  logic [DW-1:0]     rdata;
  logic [AW-1:0]     rom_addr;
  logic              rom_en;
  logic [DW-1:0]     rom_dout;

  logic [AW-1:0]     addr_v [NREQ];
  logic [DW-1:0]     rom_pipe [RD_LAT];

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  typedef struct {
    int            tag;
    logic [DW-1:0] data;
    int            due;
  } exp_t;
  exp_t sbq[$];

  // Reference model state
  int            last_srv;
  int            wins0;
  int            last_w;
  logic          exp_en;
  logic [AW-1:0] exp_addr;
  logic [DW-1:0] last_rd;

  img_rom_arbiter #(
    .NREQ(NREQ), .AW(AW), .DW(DW), .RD_LAT(RD_LAT), .STARVE_MAX(STARVE_MAX)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .addr_in(addr_in), .gnt(gnt),
    .rvalid(rvalid), .rdata(rdata), .rom_addr(rom_addr), .rom_en(rom_en),
    .rom_dout(rom_dout)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_pack
      assign addr_in[gi*AW +: AW] = addr_v[gi];
    end
  endgenerate

  function automatic logic [DW-1:0] rom_f(input logic [AW-1:0] a);
    return a[DW-1:0] ^ 12'h5A5;
  endfunction

  // ROM: rom_dout reflects rom_addr RD_LAT edges after it was presented
  always @(posedge clk) begin
    rom_pipe[0] <= rom_f(rom_addr);
    for (int s = 1; s < RD_LAT; s++) rom_pipe[s] <= rom_pipe[s-1];
  end
  assign rom_dout = rom_pipe[RD_LAT-1];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%0h expected=%0h", name, cyc, act, expv);
    end
  endtask

  // Who should win: requester 0 unless it has starved the others for
  // STARVE_MAX straight wins; else the next waiting requester after the last one served.
  function automatic int model_pick(input logic [NREQ-1:0] r);
    logic oth;
    oth = |r[NREQ-1:1];
    if (r[0] && !(STARVE_MAX != 0 && wins0 == STARVE_MAX && oth)) return 0;
    for (int k = 1; k < NREQ; k++) begin
      int c;
      c = (last_srv - 1 + k) % (NREQ - 1) + 1;
      if (r[c]) return c;
    end
    return -1;
  endfunction

  task automatic model_reset();
    last_srv = NREQ - 1;
    wins0    = 0;
    last_w   = -1;
    exp_en   = 1'b0;
    exp_addr = '0;
    last_rd  = '0;
    sbq.delete();
  endtask

  task automatic step();
    int   w;
    logic oth;
    @(negedge clk);
    chk("rom_en", {63'd0, rom_en}, {63'd0, exp_en});
    chk("rom_addr", {47'd0, rom_addr}, {47'd0, exp_addr});
    w = model_pick(req);
    chk("gnt", {60'd0, gnt}, (w < 0) ? 64'd0 : (64'd1 << w));
    oth = |req[NREQ-1:1];
    if (w >= 0) begin
      sbq.push_back('{tag: w, data: rom_f(addr_v[w]), due: cyc + RD_LAT + 2});
      $display("accept cyc=%0d req=%b req_id=%0d addr=%05h", cyc, req, w, addr_v[w]);
      exp_en   = 1'b1;
      exp_addr = addr_v[w];
    end else begin
      exp_en = 1'b0;
    end
    if (w > 0) begin
      last_srv = w;
      wins0    = 0;
    end else if (!oth) begin
      wins0 = 0;
    end else if (w == 0 && wins0 < STARVE_MAX) begin
      wins0++;
    end
    last_w = w;
    @(posedge clk);
    #1;
    if (w >= 0) addr_v[w] = AW'($urandom);
  endtask

  task automatic rnd_update();
    for (int i = 0; i < NREQ; i++) begin
      if (req[i]) begin
        if (i == last_w) begin
          if ($urandom_range(0, 3) == 0) req[i] = 1'b0;
        end else if ($urandom_range(0, 15) == 0) begin
          req[i] = 1'b0;
        end
      end else if ($urandom_range(0, 2) == 0) begin
        req[i]    = 1'b1;
        addr_v[i] = AW'($urandom);
      end
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_gnt"}, {60'd0, gnt}, 64'd0);
    chk({tag, "_rvalid"}, {60'd0, rvalid}, 64'd0);
    chk({tag, "_rdata"}, {52'd0, rdata}, 64'd0);
    chk({tag, "_rom_addr"}, {47'd0, rom_addr}, 64'd0);
    chk({tag, "_rom_en"}, {63'd0, rom_en}, 64'd0);
  endtask

  // Monitor: every rvalid pulse must match the oldest outstanding accept
  always @(negedge clk) begin
    if (rst_n) begin
      if (rvalid != '0) begin
        if (sbq.size() == 0) begin
          chk("spurious_rvalid", {60'd0, rvalid}, 64'd0);
        end else begin
          exp_t e;
          e = sbq.pop_front();
          $display("return cyc=%0d rvalid=%b rdata=%03h exp_id=%0d exp_data=%03h",
                   cyc, rvalid, rdata, e.tag, e.data);
          chk("rvalid_tag", {60'd0, rvalid}, 64'd1 << e.tag);
          chk("rdata", {52'd0, rdata}, {52'd0, e.data});
          chk("rvalid_latency", 64'(cyc), 64'(e.due));
          last_rd = e.data;
        end
      end else begin
        chk("rdata_hold", {52'd0, rdata}, {52'd0, last_rd});
        if (sbq.size() != 0 && sbq[0].due < cyc) begin
          chk("missing_rvalid", 64'(cyc), 64'(sbq[0].due));
          void'(sbq.pop_front());
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    req   = '1;
    for (int i = 0; i < NREQ; i++) addr_v[i] = AW'($urandom);
    model_reset();
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    req = '0;
    @(posedge clk);
    #3 rst_n = 1'b1;

    // Single priority read
    req       = 4'b0001;
    addr_v[0] = 17'h00123;
    step();
    req = '0;
    repeat (5) step();

    // Round-robin among the non-priority requesters
    req = 4'b1110;
    repeat (12) step();

    // Everyone busy: starvation override must break in every STARVE_MAX+1
    req = 4'b1111;
    repeat (40) step();

    // Withdrawn request while requester 0 holds the port
    req = 4'b0000;
    step();
    req = 4'b0001;
    repeat (2) step();
    req = 4'b0101;
    repeat (2) step();
    req = 4'b0001;
    repeat (2) step();
    req = 4'b1110;
    repeat (4) step();
    req = '0;
    repeat (4) step();

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      rnd_update();
      step();
    end

    // Reset with reads in flight
    req = 4'b1111;
    repeat (3) step();
    #2 rst_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    model_reset();
    @(posedge clk);
    #3 rst_n = 1'b1;
    req = 4'b1110;
    repeat (6) step();
    req = '0;
    repeat (6) step();

    chk("scoreboard_empty", 64'(sbq.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
